// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI3 burst/response encodings, FSM states and address stepping shared by the SRAM slave
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  // Every size is handled as 4 bytes and WRAP degrades to INCR.
  function automatic logic [31:0] addr_next(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// rtl/axi_sram_mem.sv - word SRAM with one registered read port and one byte-enabled write port
module axi_sram_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strb
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Array is never reset; a read and write on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 single-outstanding SRAM slave; MEM_RANGE_CHK_EN enables out-of-range SLVERR
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int AW = DEPTH_LOG2;

  function automatic logic [AW-1:0] idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef MEM_RANGE_CHK_EN
  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (AW + 2)) == 32'd0);
  endfunction
`endif

  logic unused_ok;
  assign unused_ok = ^{awsize_i, arsize_i, wid_i, wlast_i};

  rd_state_e   r_state, r_state_nxt;
  logic [3:0]  rid_q, rlen_q, rbeat_q;
  logic [1:0]  rburst_q;
  logic [31:0] raddr_q, rd_addr, rd_data;
  logic        ar_hs, r_hs, rd_fire;

  assign ar_hs     = arvalid_i && arready_o;
  assign r_hs      = rvalid_o && rready_i;
  assign arready_o = (r_state == R_IDLE);
  assign rvalid_o  = (r_state == R_DATA);
  assign rlast_o   = rvalid_o && (rbeat_q == rlen_q);
  assign rid_o     = rid_q;

  // rd_fire loads the next beat into the memory's output register.
  always_comb begin
    r_state_nxt = r_state;
    rd_fire     = 1'b0;
    rd_addr     = addr_next(raddr_q, rburst_q);
    case (r_state)
      R_IDLE: if (arvalid_i) begin
        r_state_nxt = R_DATA;
        rd_fire     = 1'b1;
        rd_addr     = araddr_i;
      end
      R_DATA: if (rready_i) begin
        if (rlast_o) r_state_nxt = R_IDLE;
        else         rd_fire     = 1'b1;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rid_q    <= '0;
      rlen_q   <= '0;
      rbeat_q  <= '0;
      rburst_q <= BURST_INCR;
      raddr_q  <= '0;
    end else begin
      if (ar_hs) begin
        rid_q    <= arid_i;
        rlen_q   <= arlen_i;
        rburst_q <= arburst_i;
        rbeat_q  <= '0;
      end else if (r_hs) begin
        rbeat_q <= rbeat_q + 4'd1;
      end
      if (rd_fire) raddr_q <= rd_addr;
    end
  end

  wr_state_e   w_state, w_state_nxt;
  logic [3:0]  bid_q, wlen_q, wbeat_q;
  logic [1:0]  wburst_q;
  logic [31:0] waddr_q;
  logic        aw_hs, w_hs, w_ok;

  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  assign awready_o = (w_state == W_IDLE);
  assign wready_o  = (w_state == W_DATA);
  assign bvalid_o  = (w_state == W_RESP);
  assign bid_o     = bid_q;

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (awvalid_i) w_state_nxt = W_DATA;
      W_DATA: if (wvalid_i && (wbeat_q == wlen_q)) w_state_nxt = W_RESP;
      W_RESP: if (bready_i) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bid_q    <= '0;
      wlen_q   <= '0;
      wbeat_q  <= '0;
      wburst_q <= BURST_INCR;
      waddr_q  <= '0;
    end else if (aw_hs) begin
      bid_q    <= awid_i;
      wlen_q   <= awlen_i;
      wburst_q <= awburst_i;
      waddr_q  <= awaddr_i;
      wbeat_q  <= '0;
    end else if (w_hs) begin
      waddr_q <= addr_next(waddr_q, wburst_q);
      wbeat_q <= wbeat_q + 4'd1;
    end
  end

`ifdef MEM_RANGE_CHK_EN
  logic werr_q, rerr_q;

  assign w_ok = in_range(waddr_q);

  // The write error is sticky across the burst; the read error tracks the beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      werr_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      if (aw_hs)              werr_q <= 1'b0;
      else if (w_hs && !w_ok) werr_q <= 1'b1;
      if (rd_fire) rerr_q <= !in_range(rd_addr);
    end
  end

  assign bresp_o = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign rresp_o = rerr_q ? RESP_SLVERR : RESP_OKAY;
  assign rdata_o = rerr_q ? 32'd0 : rd_data;
`else
  assign w_ok    = 1'b1;
  assign bresp_o = RESP_OKAY;
  assign rresp_o = RESP_OKAY;
  assign rdata_o = rd_data;
`endif

  axi_sram_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_fire),
    .rd_idx  (idx(rd_addr)),
    .rd_data (rd_data),
    .wr_en   (w_hs && w_ok),
    .wr_idx  (idx(waddr_q)),
    .wr_data (wdata_i),
    .wr_strb (wstrb_i)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed table-driven bench for axi_sram_slave
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awid = '0, wid = '0, arid = '0, awlen = '0, arlen = '0, wstrb = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [2:0]  awsize = 3'b010, arsize = 3'b010;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01;
  logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid),
    .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
    .rready_i(rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input logic [1:0] burst, input logic [3:0] strb, input logic [31:0] d0,
                          input logic [31:0] step, input logic [1:0] exp_resp, input int bstall);
    int t;
    awaddr = addr; awlen = len; awid = id; awburst = burst; awvalid = 1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("aw_timeout", 0, 1);
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d0 + i * step; wstrb = strb; wlast = (i == int'(len)); wvalid = 1; wid = 4'hF;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("w_timeout", 0, 1);
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    check("bvalid", {31'd0, bvalid}, 32'd1);
    check("bid", {28'd0, bid}, {28'd0, id});
    check("bresp", {30'd0, bresp}, {30'd0, exp_resp});
    for (int s = 0; s < bstall; s++) begin
      @(negedge clk);
      check("bvalid_hold", {31'd0, bvalid}, 32'd1);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("bvalid_drop", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input logic [1:0] burst, input logic [31:0] e0, input logic [31:0] estep,
                         input logic [1:0] exp_resp, input int stall_beat, input int stall_n);
    int t;
    araddr = addr; arlen = len; arid = id; arburst = burst; arvalid = 1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("ar_timeout", 0, 1);
    @(negedge clk);
    arvalid = 0;
    rready = 1;
    for (int i = 0; i <= int'(len); i++) begin
      check("rvalid", {31'd0, rvalid}, 32'd1);
      check("rdata", rdata, e0 + i * estep);
      check("rresp", {30'd0, rresp}, {30'd0, exp_resp});
      check("rid", {28'd0, rid}, {28'd0, id});
      check("rlast", {31'd0, rlast}, {31'd0, (i == int'(len))});
      if (i == stall_beat) begin
        rready = 0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check("rvalid_hold", {31'd0, rvalid}, 32'd1);
          check("rdata_hold", rdata, e0 + i * estep);
        end
        rready = 1;
      end
      @(negedge clk);
    end
    rready = 0;
    check("rvalid_end", {31'd0, rvalid}, 32'd0);
    check("arready_end", {31'd0, arready}, 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] d0;
    logic [31:0] step;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h14,  4'd0, 4'h1, 2'b01, 4'hF, 32'hDEADBEEF, 32'd0};
    vecs[1]  = '{1'b0, 32'h14,  4'd0, 4'h2, 2'b01, 4'hF, 32'hDEADBEEF, 32'd0};
    vecs[2]  = '{1'b1, 32'h40,  4'd3, 4'h3, 2'b01, 4'hF, 32'd1,        32'd1};
    vecs[3]  = '{1'b0, 32'h40,  4'd3, 4'h5, 2'b01, 4'hF, 32'd1,        32'd1};
    vecs[4]  = '{1'b1, 32'h0,   4'd0, 4'h6, 2'b01, 4'hF, 32'd0,        32'd0};
    vecs[5]  = '{1'b1, 32'h0,   4'd0, 4'h7, 2'b01, 4'h5, 32'hAABBCCDD, 32'd0};
    vecs[6]  = '{1'b0, 32'h0,   4'd0, 4'h8, 2'b01, 4'hF, 32'h00BB00DD, 32'd0};
    vecs[7]  = '{1'b1, 32'h100, 4'd2, 4'h9, 2'b00, 4'hF, 32'd10,       32'd1};
    vecs[8]  = '{1'b0, 32'h100, 4'd2, 4'hA, 2'b00, 4'hF, 32'd12,       32'd0};
    vecs[9]  = '{1'b1, 32'h200, 4'd1, 4'hB, 2'b10, 4'hF, 32'd20,       32'd1};
    vecs[10] = '{1'b0, 32'h200, 4'd1, 4'hC, 2'b10, 4'hF, 32'd20,       32'd1};

    #12;
    check("rst_awready", {31'd0, awready}, 32'd1);
    check("rst_arready", {31'd0, arready}, 32'd1);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rlast",   {31'd0, rlast},   32'd0);
    check("rst_ids",     {24'd0, bid, rid}, 32'd0);
    check("rst_resps",   {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].wr)
        do_write(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].burst, vecs[v].strb,
                 vecs[v].d0, vecs[v].step, 2'b00, 0);
      else
        do_read(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].burst,
                vecs[v].d0, vecs[v].step, 2'b00, -1, 0);
    end

    do_read(32'h40, 4'd3, 4'hE, 2'b01, 32'd1, 32'd1, 2'b00, 1, 3);
    do_write(32'h60, 4'd0, 4'h4, 2'b01, 4'hF, 32'h1234_5678, 32'd0, 2'b00, 5);
    do_read(32'h60, 4'd0, 4'h4, 2'b01, 32'h1234_5678, 32'd0, 2'b00, -1, 0);

    do_write(32'h80, 4'd0, 4'h1, 2'b01, 4'hF, 32'd7, 32'd0, 2'b00, 0);
    araddr = 32'h80; arlen = 0; arid = 4'h2; arburst = 2'b01; arvalid = 1;
    awaddr = 32'h80; awlen = 0; awid = 4'h3; awburst = 2'b01; awvalid = 1;
    @(negedge clk);
    arvalid = 0; awvalid = 0;
    wdata = 32'd9; wstrb = 4'hF; wlast = 1; wvalid = 1; rready = 1;
    check("conc_rvalid", {31'd0, rvalid}, 32'd1);
    check("conc_rdata_old", rdata, 32'd7);
    @(negedge clk);
    wvalid = 0; wlast = 0; rready = 0; bready = 1;
    check("conc_bvalid", {31'd0, bvalid}, 32'd1);
    check("conc_bid", {28'd0, bid}, 32'd3);
    @(negedge clk);
    bready = 0;
    do_read(32'h80, 4'd0, 4'h2, 2'b01, 32'd9, 32'd0, 2'b00, -1, 0);

`ifdef MEM_RANGE_CHK_EN
    do_write(32'h1000, 4'd0, 4'h5, 2'b01, 4'hF, 32'h55, 32'd0, 2'b10, 0);
    do_read(32'h0, 4'd0, 4'h6, 2'b01, 32'h00BB00DD, 32'd0, 2'b00, -1, 0);
    do_read(32'h1000, 4'd0, 4'h7, 2'b01, 32'd0, 32'd0, 2'b10, -1, 0);
`else
    do_write(32'h1000, 4'd0, 4'h5, 2'b01, 4'hF, 32'h55, 32'd0, 2'b00, 0);
    do_read(32'h0, 4'd0, 4'h6, 2'b01, 32'h55, 32'd0, 2'b00, -1, 0);
    do_read(32'h1000, 4'd0, 4'h7, 2'b01, 32'h55, 32'd0, 2'b00, -1, 0);
`endif

    araddr = 32'h40; arlen = 4'd7; arid = 4'h9; arburst = 2'b01; arvalid = 1;
    @(negedge clk);
    arvalid = 0; rready = 1;
    check("rb_beat1", rdata, 32'd1);
    @(negedge clk);
    check("rb_beat2", rdata, 32'd2);
    rst_n = 0;
    #1;
    check("rb_rvalid_rst", {31'd0, rvalid}, 32'd0);
    check("rb_rlast_rst", {31'd0, rlast}, 32'd0);
    @(negedge clk);
    rst_n = 1; rready = 0;
    @(negedge clk);
    check("rb_arready_after", {31'd0, arready}, 32'd1);
    check("rb_rvalid_after", {31'd0, rvalid}, 32'd0);
    do_read(32'h44, 4'd0, 4'h1, 2'b01, 32'd2, 32'd0, 2'b00, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
